// File: rtl/mips_mem_resp.sv
// Single-port word memory with an IDLE/WAIT/RESP handshake and a programmable response latency.
// Define MEM_ALIGN_CHECK_EN to flag addresses with adr[1:0] != 0 as errors.
module mips_mem_resp #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] adr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        ready,
   output logic        err
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_adr, r_wd;
   logic        r_we;
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rd;
   logic        r_ready, r_err;

   logic [31:0]   w_adr, w_wd;
   logic          w_we, w_bad, w_enter_resp;
   logic [IW-1:0] w_idx;

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         IDLE: if (req) begin
            w_cnt_nxt = 4'(LATENCY);
            w_next    = (LATENCY == 0) ? RESP : WAIT;
         end
         // Counter runs down to zero; RESP follows the cycle spent at zero.
         WAIT: begin
            if (r_cnt == 4'd0) w_next = RESP;
            else               w_cnt_nxt = r_cnt - 4'd1;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // With zero latency the response edge is also the acceptance edge, so use live inputs there.
   assign w_adr        = (r_state == IDLE) ? adr : r_adr;
   assign w_wd         = (r_state == IDLE) ? wd  : r_wd;
   assign w_we         = (r_state == IDLE) ? we  : r_we;
   assign w_enter_resp = (w_next == RESP);
   assign w_idx        = w_adr[IW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
   assign w_bad = (w_adr[31:2] >= 30'(DEPTH)) || (w_adr[1:0] != 2'b00);
`else
   logic w_unused;
   assign w_unused = ^w_adr[1:0];
   assign w_bad    = (w_adr[31:2] >= 30'(DEPTH));
`endif

   // Storage sits in the reset process only so a held reset blocks writes; it is never cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_adr   <= '0;
         r_wd    <= '0;
         r_we    <= 1'b0;
         r_rd    <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         if (r_state == IDLE && req) begin
            r_adr <= adr;
            r_wd  <= wd;
            r_we  <= we;
         end
         r_ready <= w_enter_resp;
         r_err   <= w_enter_resp && w_bad;
         if (w_enter_resp && !w_we)
            r_rd <= w_bad ? 32'h0 : r_mem[w_idx];
         if (w_enter_resp && w_we && !w_bad)
            r_mem[w_idx] <= w_wd;
      end
   end

   assign rd    = r_rd;
   assign ready = r_ready;
   assign err   = r_err;

endmodule

// File: tb/tb_mips_mem_resp.sv
// Directed bench for mips_mem_resp: one instance at LATENCY=2, one at LATENCY=0.
// Expectations for misaligned accesses follow MEM_ALIGN_CHECK_EN.
module tb_mips_mem_resp;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wd = '0;
   logic [31:0] rd;
   logic        ready, err;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] adr0 = '0, wd0 = '0;
   logic [31:0] rd0;
   logic        ready0, err0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mips_mem_resp #(.DEPTH(64), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .req(req), .adr(adr), .we(we), .wd(wd),
      .rd(rd), .ready(ready), .err(err));

   mips_mem_resp #(.DEPTH(64), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .req(req0), .adr(adr0), .we(we0), .wd(wd0),
      .rd(rd0), .ready(ready0), .err(err0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on the LATENCY=2 instance; optionally scramble inputs while it is in flight.
   task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input bit toggle);
      int hits, hit_k;
      logic [31:0] got_rd;
      logic got_err;
      hits = 0; hit_k = 0; got_rd = 'x; got_err = 1'bx;
      @(negedge clk);
      req = 1'b1; we = w; adr = a; wd = d;
      @(posedge clk); #1;
      req = 1'b0;
      if (toggle) begin
         req = 1'b1; we = ~we; adr = 32'($urandom_range(0, 63)) << 2; wd = $urandom;
      end
      for (int k = 1; k <= LAT + 3; k++) begin
         @(posedge clk); #1;
         if (ready) begin hits++; hit_k = k; got_rd = rd; got_err = err; end
         if (toggle && k <= LAT) begin
            req = 1'b1; we = ~we; adr = 32'($urandom_range(0, 63)) << 2; wd = $urandom;
         end else begin
            req = 1'b0;
         end
      end
      chk({tag, " ready_count"}, 32'(hits), 32'd1);
      chk({tag, " ready_cycle"}, 32'(hit_k), 32'(LAT + 1));
      chk({tag, " rd"}, got_rd, exp_rd);
      chk({tag, " err"}, {31'b0, got_err}, {31'b0, exp_err});
   endtask

   logic [31:0] m8;
   int          hits;

   initial begin
      // Reset held with activity on the inputs
      req = 1'b1; we = 1'b1; adr = 32'h10; wd = 32'hFFFFFFFF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready", {31'b0, ready}, 32'd0);
      chk("rst err", {31'b0, err}, 32'd0);
      chk("rst rd", rd, 32'h0);
      chk("rst ready0", {31'b0, ready0}, 32'd0);
      @(negedge clk);
      req = 1'b0; reset = 1'b1;

      txn("w10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
      txn("r10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      txn("w00", 1'b1, 32'h0, 32'h00C0FFEE, 32'hDEADBEEF, 1'b0, 1'b0);
      txn("wFC", 1'b1, 32'hFC, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0);
      txn("rFC", 1'b0, 32'hFC, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
      txn("r100", 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
      txn("w100", 1'b1, 32'h100, 32'h55555555, 32'h0, 1'b1, 1'b0);
      txn("r00", 1'b0, 32'h0, 32'h0, 32'h00C0FFEE, 1'b0, 1'b0);
      txn("w20", 1'b1, 32'h20, 32'h88888888, 32'h00C0FFEE, 1'b0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
      txn("w22", 1'b1, 32'h22, 32'h12345678, 32'h00C0FFEE, 1'b1, 1'b0);
      m8 = 32'h88888888;
`else
      txn("w22", 1'b1, 32'h22, 32'h12345678, 32'h00C0FFEE, 1'b0, 1'b0);
      m8 = 32'h12345678;
`endif
      txn("r20", 1'b0, 32'h20, 32'h0, m8, 1'b0, 1'b0);

      // Inputs scrambled during WAIT must not disturb the accepted transaction
      txn("tog w30", 1'b1, 32'h30, 32'h0BADF00D, m8, 1'b0, 1'b1);
      txn("tog r10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      txn("r30", 1'b0, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

      // Reset during WAIT of a write aborts it
      txn("w08 old", 1'b1, 32'h8, 32'h11112222, 32'h0BADF00D, 1'b0, 1'b0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; adr = 32'h8; wd = 32'hCAFEF00D;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("abort ready", {31'b0, ready}, 32'd0);
      chk("abort err", {31'b0, err}, 32'd0);
      chk("abort rd", rd, 32'h0);
      hits = 0;
      repeat (2) begin @(posedge clk); #1; if (ready) hits++; end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin @(posedge clk); #1; if (ready) hits++; end
      chk("abort no_ready", 32'(hits), 32'd0);
      txn("r08", 1'b0, 32'h8, 32'h0, 32'h11112222, 1'b0, 1'b0);

      // LATENCY=0 instance: single writes, then back-to-back reads
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; adr0 = 32'h0; wd0 = 32'h11111111;
      @(posedge clk); #1;
      req0 = 1'b0;
      chk("l0 w0 ready", {31'b0, ready0}, 32'd1);
      chk("l0 w0 err", {31'b0, err0}, 32'd0);
      @(posedge clk); #1;
      chk("l0 w0 ready_off", {31'b0, ready0}, 32'd0);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; adr0 = 32'h4; wd0 = 32'h22222222;
      @(posedge clk); #1;
      req0 = 1'b0;
      chk("l0 w4 ready", {31'b0, ready0}, 32'd1);
      @(posedge clk); #1;
      chk("l0 w4 ready_off", {31'b0, ready0}, 32'd0);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; adr0 = 32'h0;
      @(posedge clk); #1;
      chk("l0 b2b r0 ready", {31'b0, ready0}, 32'd1);
      chk("l0 b2b r0 rd", rd0, 32'h11111111);
      adr0 = 32'h4;
      @(posedge clk); #1;
      chk("l0 b2b gap", {31'b0, ready0}, 32'd0);
      @(posedge clk); #1;
      chk("l0 b2b r4 ready", {31'b0, ready0}, 32'd1);
      chk("l0 b2b r4 rd", rd0, 32'h22222222);
      chk("l0 b2b r4 err", {31'b0, err0}, 32'd0);
      req0 = 1'b0;
      @(posedge clk); #1;
      chk("l0 end ready", {31'b0, ready0}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
